// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matmul_seq_ctrl
// Description : Sequencer for an N x N matrix multiply C = A * B. It walks the
//               output index (i,j) and the reduction index k, issues operand
//               buffer reads, drives MAC enable / accumulator clear aligned to
//               the returned read data, and hands each finished C element to
//               write-back with a valid/ready handshake.
// Parameters  : N       matrix dimension (>= 2)
//               RD_LAT  operand-buffer read latency in cycles (>= 1)
//               IW, AW  derived index / address widths
// Ports       : clk, rst                     clock, synchronous active-high reset
//               start                        begin one multiply (sampled in IDLE)
//               busy, done                   status; done is a one-cycle pulse
//               rd_en, a_addr, b_addr        operand buffer read request
//               mac_en, acc_clr              MAC control, aligned to read data
//               c_wr, c_addr, c_ready        C element write-back handshake
//               perf_cycles                  busy-cycle counter (optional)
// Options     : MATMUL_SEQ_PERF_EN  adds the perf_cycles output and counter
// Revision    : 1.0  initial release
// ============================================================================
module matmul_seq_ctrl #(
    parameter  int N      = 4,
    parameter  int RD_LAT = 1,
    localparam int IW     = $clog2(N),
    localparam int AW     = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_en,
    output logic          acc_clr,
    output logic          c_wr,
    output logic [AW-1:0] c_addr,
`ifdef MATMUL_SEQ_PERF_EN
    output logic [31:0]   perf_cycles,
`endif
    input  logic          c_ready
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int DW = $clog2(RD_LAT + 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_FIN   = 3'd4;

    localparam logic [IW-1:0] c_LAST      = IW'(N - 1);
    localparam logic [AW-1:0] c_N         = AW'(N);
    localparam logic [DW-1:0] c_DRAIN_END = DW'(RD_LAT);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [IW-1:0]     r_i;
    logic [IW-1:0]     r_j;
    logic [IW-1:0]     r_k;
    logic [DW-1:0]     r_drain;
    logic [RD_LAT-1:0] r_mac_pipe;
    logic [RD_LAT-1:0] r_clr_pipe;

    // Row-major flat address: row*N + col, computed in AW bits (max N*N-1).
    function automatic logic [AW-1:0] f_addr(input logic [IW-1:0] row,
                                              input logic [IW-1:0] col);
        f_addr = AW'(row) * c_N + AW'(col);
    endfunction

    // ------------------------------------------------------------------------
    // Index stepping
    // ------------------------------------------------------------------------
    logic [IW-1:0] w_k_inc;
    logic          w_last_k;
    logic          w_last_col;
    logic          w_last_elem;
    logic [IW-1:0] w_next_i;
    logic [IW-1:0] w_next_j;
    logic          w_clr_in;

    always_comb begin
        w_k_inc     = r_k + IW'(1);
        w_last_k    = (r_k == c_LAST);
        w_last_col  = (r_j == c_LAST);
        w_last_elem = w_last_col && (r_i == c_LAST);
        w_next_i    = r_i;
        w_next_j    = r_j + IW'(1);
        if (w_last_col) begin
            w_next_i = r_i + IW'(1);
            w_next_j = '0;
        end
        // The k==0 read starts a new dot product: its product must load,
        // not accumulate onto the previous element.
        w_clr_in = rd_en && (r_k == '0);
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM (all outputs registered)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_drain <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            a_addr  <= '0;
            b_addr  <= '0;
            c_wr    <= 1'b0;
            c_addr  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state <= c_ISSUE;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        a_addr  <= '0;
                        b_addr  <= '0;
                    end
                end

                // One read per cycle; the registered address always reflects
                // the k currently held in r_k.
                c_ISSUE: begin
                    if (w_last_k) begin
                        r_state <= c_DRAIN;
                        r_k     <= '0;
                        r_drain <= '0;
                        rd_en   <= 1'b0;
                    end else begin
                        r_k    <= w_k_inc;
                        a_addr <= f_addr(r_i, w_k_inc);
                        b_addr <= f_addr(w_k_inc, r_j);
                    end
                end

                // Wait for the last read to return and pass the MAC register.
                c_DRAIN: begin
                    if (r_drain == c_DRAIN_END) begin
                        r_state <= c_WRITE;
                        c_wr    <= 1'b1;
                        c_addr  <= f_addr(r_i, r_j);
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end

                c_WRITE: begin
                    if (c_ready) begin
                        c_wr <= 1'b0;
                        if (w_last_elem) begin
                            r_state <= c_FIN;
                            done    <= 1'b1;
                        end else begin
                            r_state <= c_ISSUE;
                            r_i     <= w_next_i;
                            r_j     <= w_next_j;
                            r_k     <= '0;
                            rd_en   <= 1'b1;
                            a_addr  <= f_addr(w_next_i, '0);
                            b_addr  <= f_addr('0, w_next_j);
                        end
                    end
                end

                c_FIN: begin
                    r_state <= c_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= c_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    rd_en   <= 1'b0;
                    c_wr    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // MAC control: read strobe delayed by exactly the buffer read latency so
    // that mac_en/acc_clr line up with the returned operand data.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mac_pipe <= '0;
            r_clr_pipe <= '0;
        end else begin
            r_mac_pipe[0] <= rd_en;
            r_clr_pipe[0] <= w_clr_in;
            for (int p = 1; p < RD_LAT; p++) begin
                r_mac_pipe[p] <= r_mac_pipe[p-1];
                r_clr_pipe[p] <= r_clr_pipe[p-1];
            end
        end
    end

    assign mac_en  = r_mac_pipe[RD_LAT-1];
    assign acc_clr = r_clr_pipe[RD_LAT-1];

`ifdef MATMUL_SEQ_PERF_EN
    // ------------------------------------------------------------------------
    // Busy-cycle counter: cleared on an accepted start, saturating, holds its
    // value in IDLE so software can read it after done.
    // ------------------------------------------------------------------------
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (r_state == c_IDLE && start) begin
            r_perf <= '0;
        end else if (busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_seq_ctrl
// Description : Self-checking bench for matmul_seq_ctrl (N=4, RD_LAT=1).
//               Table-driven check of the first element's read/MAC timing,
//               plus directed multi-cycle sequences: reset mid-ISSUE, full
//               run ordering/latency, write-back stall, ignored start pulses,
//               and the optional busy-cycle counter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_matmul_seq_ctrl;

    localparam int N  = 4;
    localparam int RL = 1;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          c_ready;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          mac_en;
    logic          acc_clr;
    logic          c_wr;
    logic [AW-1:0] c_addr;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    matmul_seq_ctrl #(.N(N), .RD_LAT(RL)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .a_addr      (a_addr),
        .b_addr      (b_addr),
        .mac_en      (mac_en),
        .acc_clr     (acc_clr),
        .c_wr        (c_wr),
        .c_addr      (c_addr),
`ifdef MATMUL_SEQ_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .c_ready     (c_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    32'(busy),    0);
        chk({tag, "_done"},    32'(done),    0);
        chk({tag, "_rd_en"},   32'(rd_en),   0);
        chk({tag, "_a_addr"},  32'(a_addr),  0);
        chk({tag, "_b_addr"},  32'(b_addr),  0);
        chk({tag, "_mac_en"},  32'(mac_en),  0);
        chk({tag, "_acc_clr"}, 32'(acc_clr), 0);
        chk({tag, "_c_wr"},    32'(c_wr),    0);
        chk({tag, "_c_addr"},  32'(c_addr),  0);
    endtask

    // One full multiply. Cycle 1 is the cycle after the start-sampling edge.
    task automatic run_op(input int stall_addr, input int stall_len,
                          input int busy_start_at, input bit start_at_done,
                          output int done_cyc, output int n_done, output int n_wr,
                          output int order_err, output int stall_hold,
                          output int rd_during_wr, output bit finished);
        int stall_left;
        done_cyc = 0; n_done = 0; n_wr = 0; order_err = 0;
        stall_hold = 0; rd_during_wr = 0; finished = 1'b0;
        stall_left = stall_len;
        c_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (n_done > 0 && !busy) begin
                finished = 1'b1;
                break;
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
                if (start_at_done) start = 1'b1;
            end
            if (c_wr && rd_en) rd_during_wr++;
            if (c_wr && int'(c_addr) == stall_addr) stall_hold++;
            c_ready = 1'b1;
            if (c_wr && int'(c_addr) == stall_addr && stall_left > 0) begin
                c_ready = 1'b0;
                stall_left--;
            end
            if (c_wr && c_ready) begin
                if (int'(c_addr) != n_wr) order_err++;
                n_wr++;
            end
            if (cyc == busy_start_at) start = 1'b1;
            step();
            start = 1'b0;
        end
        c_ready = 1'b1;
    endtask

    typedef struct {
        logic          rd_en;
        logic [AW-1:0] a_addr;
        logic [AW-1:0] b_addr;
        logic          mac_en;
        logic          acc_clr;
        logic          busy;
        logic          c_wr;
    } vec_t;

    vec_t vec [8];

    int done_cyc, n_done, n_wr, order_err, stall_hold, rd_wr;
    bit finished;

    initial begin
        // Expected outputs for cycles 1..8 after start: first element's four
        // reads (a = k, b = 4k), MAC one cycle behind, two DRAIN cycles,
        // one WRITE, then the first read of element (0,1).
        vec[0] = '{1'b1, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        vec[1] = '{1'b1, 4'd1, 4'd4,  1'b1, 1'b1, 1'b1, 1'b0};
        vec[2] = '{1'b1, 4'd2, 4'd8,  1'b1, 1'b0, 1'b1, 1'b0};
        vec[3] = '{1'b1, 4'd3, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[4] = '{1'b0, 4'd3, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[5] = '{1'b0, 4'd3, 4'd12, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[6] = '{1'b0, 4'd3, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[7] = '{1'b1, 4'd0, 4'd1,  1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; c_ready = 1'b1;
        repeat (3) step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 0);

        // First element timing, table-driven.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("t%0d_rd_en", r),   32'(rd_en),   32'(vec[r].rd_en));
            chk($sformatf("t%0d_a_addr", r),  32'(a_addr),  32'(vec[r].a_addr));
            chk($sformatf("t%0d_b_addr", r),  32'(b_addr),  32'(vec[r].b_addr));
            chk($sformatf("t%0d_mac_en", r),  32'(mac_en),  32'(vec[r].mac_en));
            chk($sformatf("t%0d_acc_clr", r), 32'(acc_clr), 32'(vec[r].acc_clr));
            chk($sformatf("t%0d_busy", r),    32'(busy),    32'(vec[r].busy));
            chk($sformatf("t%0d_c_wr", r),    32'(c_wr),    32'(vec[r].c_wr));
            if (vec[r].c_wr) chk($sformatf("t%0d_c_addr", r), 32'(c_addr), 0);
            step();
        end

        // Reset held 3 cycles mid-ISSUE (element 1, k=1).
        chk("pre_rst_rd_en", 32'(rd_en), 1);
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step();
            chk_all_zero($sformatf("midrst%0d", r));
        end
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_mac_en", 32'(mac_en), 0);

        // Full run, c_ready tied high.
        run_op(-1, 0, 0, 1'b0, done_cyc, n_done, n_wr, order_err, stall_hold, rd_wr, finished);
        chk("run_finished", 32'(finished), 1);
        chk("run_done_cycle", 32'(done_cyc), 113);
        chk("run_done_count", 32'(n_done), 1);
        chk("run_writes", 32'(n_wr), 16);
        chk("run_order_err", 32'(order_err), 0);
        chk("run_rd_during_wr", 32'(rd_wr), 0);
        chk("run_busy_after", 32'(busy), 0);
`ifdef MATMUL_SEQ_PERF_EN
        chk("perf_after_done", perf_cycles, 113);
        repeat (3) step();
        chk("perf_in_idle", perf_cycles, 113);
`endif

        // Write-back stall: c_ready low 5 cycles on element 6.
        run_op(6, 5, 0, 1'b0, done_cyc, n_done, n_wr, order_err, stall_hold, rd_wr, finished);
        chk("stall_finished", 32'(finished), 1);
        chk("stall_done_cycle", 32'(done_cyc), 118);
        chk("stall_hold_cycles", 32'(stall_hold), 6);
        chk("stall_rd_during_wr", 32'(rd_wr), 0);
        chk("stall_writes", 32'(n_wr), 16);
        chk("stall_order_err", 32'(order_err), 0);

        // start while busy and start coincident with done are both ignored.
        run_op(-1, 0, 50, 1'b1, done_cyc, n_done, n_wr, order_err, stall_hold, rd_wr, finished);
        chk("ign_finished", 32'(finished), 1);
        chk("ign_done_count", 32'(n_done), 1);
        chk("ign_done_cycle", 32'(done_cyc), 113);
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("ign_idle_busy%0d", r), 32'(busy), 0);
            chk($sformatf("ign_idle_rd%0d", r), 32'(rd_en), 0);
            step();
        end

        // A fresh start after that runs normally.
        run_op(-1, 0, 0, 1'b0, done_cyc, n_done, n_wr, order_err, stall_hold, rd_wr, finished);
        chk("next_finished", 32'(finished), 1);
        chk("next_done_cycle", 32'(done_cyc), 113);
        chk("next_writes", 32'(n_wr), 16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
